// File: rtl/special_walls_2_renderer_if.sv
// Bundle between the VGA/ROM side and the special-wall-2 renderer.
// master = VGA controller + sprite ROM, slave = renderer.
interface special_walls_2_renderer_if;
  logic       frame_start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] wall_x;
  logic [9:0] wall_y;
  logic       flash_start;
  logic [3:0] flash_count;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic       pixel_valid;
  logic [3:0] pixel_index;
  logic       flash_busy;
  logic       flash_done;

  modport master (
    output frame_start,
    output DrawX,
    output DrawY,
    output wall_x,
    output wall_y,
    output flash_start,
    output flash_count,
    output rom_data,
    input  rom_addr,
    input  pixel_valid,
    input  pixel_index,
    input  flash_busy,
    input  flash_done
  );

  modport slave (
    input  frame_start,
    input  DrawX,
    input  DrawY,
    input  wall_x,
    input  wall_y,
    input  flash_start,
    input  flash_count,
    input  rom_data,
    output rom_addr,
    output pixel_valid,
    output pixel_index,
    output flash_busy,
    output flash_done
  );
endinterface

// File: rtl/special_walls_2_renderer.sv
// Special-wall-2 sprite renderer: 2-stage pixel pipeline plus flash FSM.
// Ports: Clk, Reset (async, active-high), bus (slave: draw/wall/flash in, rom, pixel/flash out).
module special_walls_2_renderer #(
  parameter int         SPRITE_W     = 8,
  parameter int         SPRITE_H     = 20,
  parameter int         ROM_DEPTH    = 167,
  parameter logic [3:0] TRANSPARENT  = 4'hF,
  parameter int         FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  special_walls_2_renderer_if.slave bus
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    DONE
  } state_t;

  // ---------------- stage 1 ----------------
  // 11-bit arithmetic keeps origin + size from wrapping at the screen edge.
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] ox;
  logic [10:0] oy;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic [21:0] addr_full;
  logic        in_rom;

  logic       hit1;
  logic [7:0] rom_addr_q;

  assign px = {1'b0, bus.DrawX};
  assign py = {1'b0, bus.DrawY};
  assign ox = {1'b0, bus.wall_x};
  assign oy = {1'b0, bus.wall_y};
  assign dx = px - ox;
  assign dy = py - oy;

  assign in_box = (px >= ox) &&
                  (px < ox + 11'(SPRITE_W)) &&
                  (py >= oy) &&
                  (py < oy + 11'(SPRITE_H));

  assign addr_full = 22'(dy) * 22'(SPRITE_W) + 22'(dx);

  // Addresses past the populated ROM are treated as a miss.
  assign in_rom = in_box && (addr_full < 22'(ROM_DEPTH));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit1       <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      hit1       <= in_rom;
      rom_addr_q <= in_rom ? addr_full[7:0] : 8'd0;
    end
  end

  assign bus.rom_addr = rom_addr_q;

  // ---------------- flash FSM ----------------
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_n;
  logic [3:0]       remaining;
  logic [3:0]       remaining_n;
  logic             frame_last;
  logic             flash_off;

  assign frame_last = (frame_cnt + CNT_W'(1)) == CNT_W'(FLASH_FRAMES);
  assign flash_off  = (state == OFF);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      remaining <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    remaining_n = remaining;
    unique case (state)
      IDLE: begin
        // A coincident frame_start is not counted on entry.
        if (bus.flash_start) begin
          if (bus.flash_count != 4'd0) begin
            state_n     = ON;
            remaining_n = bus.flash_count;
            frame_cnt_n = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      ON: begin
        if (bus.frame_start) begin
          if (frame_last) begin
            state_n     = OFF;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      OFF: begin
        if (bus.frame_start) begin
          if (frame_last) begin
            frame_cnt_n = '0;
            remaining_n = remaining - 4'd1;
            state_n     = (remaining == 4'd1) ? DONE : ON;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.flash_busy = (state != IDLE);
  assign bus.flash_done = (state == DONE);

  // ---------------- stage 2 ----------------
  logic       pix_valid_q;
  logic [3:0] pix_index_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
    end else begin
      pix_index_q <= bus.rom_data;
      pix_valid_q <= hit1 &&
                     (bus.rom_data != TRANSPARENT) &&
                     !flash_off;
    end
  end

  assign bus.pixel_valid = pix_valid_q;
  assign bus.pixel_index = pix_index_q;

endmodule

// File: doc/special_walls_2_renderer.md
Name: special_walls_2_renderer

Overview:
- Downstream consumer of the special-wall-2 sprite ROM.
- Converts VGA draw coordinates into a ROM address for one special-wall sprite placed at a programmable origin.
- Registers the returned 4-bit palette index and qualifies it with hit, transparency and flash state.
- Drives a frame-counted flash state machine that blinks the wall, used for level-complete and power-pellet effects.
- Output feeds the colour mapper's layer mux.

Parameters:
- SPRITE_W, 8: sprite width in pixels.
- SPRITE_H, 20: sprite height in pixels.
- ROM_DEPTH, 167: number of valid ROM entries. Any address >= ROM_DEPTH is a miss.
- TRANSPARENT, 4'hF: palette index treated as transparent.
- FLASH_FRAMES, 8: frames per ON phase and per OFF phase.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame from the VGA controller (vsync edge).
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- wall_x  in  10  sprite origin x; sampled every cycle.
- wall_y  in  10  sprite origin y; sampled every cycle.
- flash_start  in  1  one-cycle request to begin flashing.
- flash_count  in  4  number of ON/OFF cycles, sampled on an accepted flash_start.
- rom_addr  out  8  address to the ROM.
- rom_data  in  4  ROM data; the ROM is combinational from rom_addr.
- pixel_valid  out  1  high when pixel_index must be drawn.
- pixel_index  out  4  palette index.
- flash_busy  out  1  high while the FSM is not IDLE.
- flash_done  out  1  one-cycle pulse when a flash sequence ends.

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: all pipeline registers 0, so rom_addr=0, pixel_valid=0, pixel_index=0. flash_busy=0, flash_done=0. FSM in IDLE, counters 0.
- Stage 1, registered:
  - dx = DrawX - wall_x and dy = DrawY - wall_y, computed 11 bits wide.
  - hit1 = (DrawX >= wall_x) & (DrawX < wall_x + SPRITE_W) & (DrawY >= wall_y) & (DrawY < wall_y + SPRITE_H).
  - Compare in 11 bits so wall_x + SPRITE_W > 1023 does not wrap.
  - addr = dy*SPRITE_W + dx. If addr >= ROM_DEPTH, force hit1=0 and rom_addr=0.
  - rom_addr is driven from the stage-1 register.
- Stage 2, registered:
  - pixel_index <= rom_data.
  - pixel_valid <= hit1 & (rom_data != TRANSPARENT) & ~flash_off.
- Latency: DrawX/DrawY presented at cycle N produce pixel_valid/pixel_index at cycle N+2. The pipeline runs every cycle with no stall.
- Flash FSM states: IDLE, ON, OFF, DONE. flash_off = (state == OFF).
- IDLE:
  - flash_start with flash_count != 0 goes to ON. It loads remaining = flash_count and clears frame_cnt.
  - flash_start with flash_count == 0 goes to DONE.
- ON: each frame_start increments frame_cnt. On the frame_start that makes frame_cnt == FLASH_FRAMES, go to OFF and clear frame_cnt.
- OFF: frame counting is the same as ON. At FLASH_FRAMES:
  - remaining decrements.
  - If the new remaining is 0, go to DONE; otherwise go to ON.
- DONE: flash_done = 1 for exactly this cycle, then go to IDLE.
- flash_busy = (state != IDLE).
- flash_start while busy (ON, OFF or DONE) is ignored.
- Simultaneous flash_start and frame_start in IDLE: the start is accepted, and that frame_start is not counted.
- Reset asserted mid-sequence returns everything to reset values immediately, without waiting for a clock edge. No flash_done is emitted.
- Changing wall_x/wall_y mid-frame takes effect for pixels sampled from the next cycle.
- rom_data is only meaningful when hit1=1. When hit1=0, pixel_valid must be 0 regardless of rom_data.

Test Plan:
1. Hit, opaque: Reset, wall_x=100, wall_y=50, DrawX=103, DrawY=52, ROM model returns 4'h3 at address 19 -> rom_addr=19 at N+1; pixel_valid=1 and pixel_index=3 at N+2.
2. Transparent and miss: DrawX=103, DrawY=52 with rom_data=4'hF -> pixel_valid=0. DrawX=99 (left of origin) -> pixel_valid=0. DrawX=108 (x boundary) -> pixel_valid=0.
3. Address clamp:
   - wall at (0,0), DrawX=7, DrawY=20 (outside SPRITE_H) -> pixel_valid=0.
   - Model ROM_DEPTH=150 with DrawY=19, DrawX=0, giving addr=152 -> pixel_valid=0, rom_addr=0.
   - Edge wrap: wall_x=1020, DrawX=1023 -> hit (dx=3).
4. Flash sequence: flash_start with flash_count=2 over 32+ frame_start pulses:
   - ON for 8 frames, OFF for 8, ON for 8, OFF for 8.
   - flash_done pulses once, one cycle after the 32nd counted frame_start.
   - pixel_valid is 0 throughout the OFF phases on an opaque hit.
   - flash_busy is 1 from acceptance until DONE.
5. Edge starts:
   - flash_count=0 -> flash_done the next cycle, no ON phase.
   - flash_start during ON is ignored (remaining unchanged).
   - flash_start and frame_start together in IDLE -> frame_cnt=0 after entry.
6. Async reset mid-OFF: assert Reset between clock edges -> flash_busy=0 and pixel_valid=0 immediately. No flash_done. A new flash_start after release behaves as a fresh start.
